// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial A - B - Bin subtractor, LSB first, one bit per clock.
// Three-state FSM (IDLE/RUN/DONE); results are registered and only updated on DONE entry.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow,
  output logic             Overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic             bit_d;
  logic             br_nxt;
  logic [WIDTH-1:0] res_shift;

  always_comb begin
    bit_d     = a_q[0] ^ b_q[0] ^ br_q;
    br_nxt    = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    res_shift = res_q >> 1;
    res_shift[WIDTH-1] = bit_d;

    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    br_d     = br_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          br_d    = Bin;
          a_msb_d = A[WIDTH-1];
          b_msb_d = B[WIDTH-1];
          cnt_d   = '0;
          res_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = br_nxt;
        res_d = res_shift;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Sign bits were saved at capture because the shifters have consumed them by now.
          state_d  = S_DONE;
          cnt_d    = '0;
          diff_d   = res_shift;
          borrow_d = br_nxt;
          ovf_d    = (a_msb_q != b_msb_q) && (res_shift[WIDTH-1] != a_msb_q);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      br_q     <= br_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign Diff     = diff_q;
  assign Borrow   = borrow_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=1.
module tb_serial_subtractor;

  typedef struct {
    logic [7:0] d;
    logic       br;
    logic       ov;
    int         acc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start8, bin8, busy8, done8, borrow8, ovf8;
  logic [7:0] a8, b8, diff8;
  logic       start1, bin1, busy1, done1, borrow1, ovf1;
  logic [0:0] a1, b1, diff1;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t q8[$];
  exp_t q1[$];
  logic [7:0] last_diff8 = 8'h00;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .Bin(bin8),
    .busy(busy8), .done(done8), .Diff(diff8), .Borrow(borrow8), .Overflow(ovf8)
  );

  serial_subtractor #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1), .Bin(bin1),
    .busy(busy1), .done(done1), .Diff(diff1), .Borrow(borrow1), .Overflow(ovf1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done8) begin
      if (q8.size() == 0) begin
        chk("done8_spurious", done8, 0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("diff8", diff8, e.d);
        chk("borrow8", borrow8, e.br);
        chk("ovf8", ovf8, e.ov);
        chk("latency8", cyc - e.acc, 9);
      end
    end
  end

  always @(negedge clk) begin
    if (done1) begin
      if (q1.size() == 0) begin
        chk("done1_spurious", done1, 0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("diff1", diff1, e.d[0]);
        chk("borrow1", borrow1, e.br);
        chk("ovf1", ovf1, e.ov);
        chk("latency1", cyc - e.acc, 2);
      end
    end
  end

  task automatic wait_idle8();
    int n = 0;
    while (busy8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy8) chk("idle8_timeout", busy8, 0);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bin,
                      input logic [7:0] d, input logic br, input logic ov);
    int nb = 0;
    int held_bad = 0;
    wait_idle8();
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
    q8.push_back('{d, br, ov, cyc});
    @(negedge clk);
    start8 = 1'b0; a8 = ~a; b8 = ~b; bin8 = ~bin;
    for (int i = 0; i < 20; i++) begin
      if (!busy8) break;
      nb++;
      if (!done8 && diff8 !== last_diff8) held_bad++;
      @(negedge clk);
    end
    chk("busy8_cycles", nb, 9);
    chk("diff8_held_during_run", held_bad, 0);
    last_diff8 = d;
  endtask

  task automatic run1(input logic a, input logic b, input logic d, input logic br, input logic ov);
    int nb = 0;
    @(negedge clk);
    start1 = 1'b1; a1 = a; b1 = b; bin1 = 1'b0;
    q1.push_back('{{7'd0, d}, br, ov, cyc});
    @(negedge clk);
    start1 = 1'b0; a1 = ~a; b1 = ~b;
    for (int i = 0; i < 10; i++) begin
      if (!busy1) break;
      nb++;
      @(negedge clk);
    end
    chk("busy1_cycles", nb, 2);
  endtask

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
    #1;
    chk("rst_outputs8", {busy8, done8, diff8, borrow8, ovf8}, 0);
    chk("rst_outputs1", {busy1, done1, diff1, borrow1, ovf1}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    run8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    run8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    run8(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    run8(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
    run8(8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0);

    // start pulsed mid-RUN with different operands must be ignored
    wait_idle8();
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h42; b8 = 8'h11; bin8 = 1'b0;
    q8.push_back('{8'h31, 1'b0, 1'b0, cyc});
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_idle8();
    repeat (3) @(negedge clk);
    chk("intrude_q8_drained", q8.size(), 0);
    chk("intrude_diff8_kept", diff8, 8'h31);
    last_diff8 = 8'h31;

    // asynchronous reset 4 cycles into RUN aborts without a done pulse
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h20; b8 = 8'h30; bin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst8", {busy8, done8, diff8, borrow8, ovf8}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_diff8 = 8'h00;
    run8(8'h05, 8'h07, 1'b1, 8'hFD, 1'b1, 1'b0);

    // start held high: second op accepted on first IDLE cycle after DONE
    wait_idle8();
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hC8; b8 = 8'h37; bin8 = 1'b0;
    q8.push_back('{8'h91, 1'b0, 1'b0, cyc});
    q8.push_back('{8'hC8, 1'b1, 1'b1, cyc + 10});
    @(negedge clk);
    a8 = 8'h64; b8 = 8'h9C;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (q8.size() == 0) break;
    end
    start8 = 1'b0;
    chk("b2b_q8_drained", q8.size(), 0);
    last_diff8 = 8'hC8;

    run1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    run1(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    run1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run1(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    repeat (15) @(negedge clk);
    chk("final_q8_drained", q8.size(), 0);
    chk("final_q1_drained", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
